// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM states,
// sign_mask codes understood by the data memory, and the ack timeout default.
package dmem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

    localparam int ACK_TIMEOUT_DEFAULT = 4;

    localparam logic [3:0] SM_WORD   = 4'b0000;
    localparam logic [3:0] SM_HALF   = 4'b0010;
    localparam logic [3:0] SM_BYTE   = 4'b0100;
    localparam logic [3:0] SM_HALF_U = 4'b1010;
    localparam logic [3:0] SM_BYTE_U = 4'b1100;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester grant selection: round-robin against the last grant, or
// strict port-0 priority when FIXED_PRIO is non-zero. Purely combinational.
module rr_arb2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       grant
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        valid = |req;
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a CPU port and a loader/debug port onto one stalling data
// memory: latch the winner, strobe one command, wait for the stall handshake.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT,
    parameter int FIXED_PRIO  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_mask,
    output logic [31:0] p0_rdata,
    output logic        p0_done,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_mask,
    output logic [31:0] p1_rdata,
    output logic        p1_done,
    output logic        p1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_sign_mask,
    output logic        mem_memread,
    output logic        mem_memwrite,
    input  logic [31:0] mem_read_data,
    input  logic        mem_stall,
    output logic        busy
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1) + 1;

    state_t           state;
    logic             last_grant;
    logic             grant;
    logic             lat_we;
    logic [CNT_W-1:0] ack_cnt;

    logic             arb_valid;
    logic             arb_grant;
    logic             sel_we;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;
    logic [3:0]       sel_mask;

    rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .req        ({p1_req, p0_req}),
        .last_grant (last_grant),
        .valid      (arb_valid),
        .grant      (arb_grant)
    );

    assign sel_we    = arb_grant ? p1_we    : p0_we;
    assign sel_addr  = arb_grant ? p1_addr  : p0_addr;
    assign sel_wdata = arb_grant ? p1_wdata : p0_wdata;
    assign sel_mask  = arb_grant ? p1_mask  : p0_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            last_grant    <= 1'b1;
            grant         <= 1'b0;
            lat_we        <= 1'b0;
            ack_cnt       <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_sign_mask <= '0;
            mem_memread   <= 1'b0;
            mem_memwrite  <= 1'b0;
            p0_rdata      <= '0;
            p1_rdata      <= '0;
            p0_done       <= 1'b0;
            p1_done       <= 1'b0;
            p0_err        <= 1'b0;
            p1_err        <= 1'b0;
            busy          <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults make strobes and done/err single-cycle pulses.
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            p0_done      <= 1'b0;
            p1_done      <= 1'b0;
            p0_err       <= 1'b0;
            p1_err       <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // A memory still busy from elsewhere must settle before we issue.
                    if (arb_valid && !mem_stall) begin
                        grant         <= arb_grant;
                        last_grant    <= arb_grant;
                        lat_we        <= sel_we;
                        mem_addr      <= sel_addr;
                        mem_wdata     <= sel_wdata;
                        mem_sign_mask <= sel_mask;
                        mem_memread   <= ~sel_we;
                        mem_memwrite  <= sel_we;
                        ack_cnt       <= '0;
                        busy          <= 1'b1;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (mem_stall) begin
                        state <= ST_WAIT_DONE;
                    end else if (ack_cnt == CNT_W'(ACK_TIMEOUT)) begin
                        p0_done <= ~grant;
                        p1_done <= grant;
                        p0_err  <= ~grant;
                        p1_err  <= grant;
                        state   <= ST_RESP;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!mem_stall) begin
                        if (!lat_we) begin
                            if (grant) p1_rdata <= mem_read_data;
                            else       p0_rdata <= mem_read_data;
                        end
                        p0_done <= ~grant;
                        p1_done <= grant;
                        state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a round-robin instance on a stalling
// memory model plus a fixed-priority instance for the strict-priority case.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int T = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        p0_req, p0_we, p0_done, p0_err;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic [3:0]  p0_mask;
    logic        p1_req, p1_we, p1_done, p1_err;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic [3:0]  p1_mask;
    logic [31:0] mem_addr, mem_wdata, mem_read_data;
    logic [3:0]  mem_sign_mask;
    logic        mem_memread, mem_memwrite, mem_stall, busy;
    logic        model_stall, model_left, force_stall, mem_dead;

    logic        f0_req, f1_req, f0_done, f1_done, f0_err, f1_err;
    logic [31:0] f0_rdata, f1_rdata, f_addr, f_wdata, f_read_data;
    logic [3:0]  f_mask;
    logic        f_memread, f_memwrite, f_stall, f_left, f_busy;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_rd [2];
    int          checks = 0;
    int          failures = 0;
    int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
    logic [31:0] last_cmd_addr, last_cmd_wdata;
    logic [3:0]  last_cmd_mask;

    function automatic logic [31:0] model_data(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
    endfunction

    dmem_arbiter #(.ACK_TIMEOUT(T), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_mask(p0_mask),
        .p0_rdata(p0_rdata), .p0_done(p0_done), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_mask(p1_mask),
        .p1_rdata(p1_rdata), .p1_done(p1_done), .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sign_mask(mem_sign_mask),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_read_data(mem_read_data), .mem_stall(mem_stall), .busy(busy)
    );

    dmem_arbiter #(.ACK_TIMEOUT(T), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .p0_req(f0_req), .p0_we(1'b0), .p0_addr(32'h40), .p0_wdata(32'h0), .p0_mask(SM_WORD),
        .p0_rdata(f0_rdata), .p0_done(f0_done), .p0_err(f0_err),
        .p1_req(f1_req), .p1_we(1'b0), .p1_addr(32'h80), .p1_wdata(32'h0), .p1_mask(SM_WORD),
        .p1_rdata(f1_rdata), .p1_done(f1_done), .p1_err(f1_err),
        .mem_addr(f_addr), .mem_wdata(f_wdata), .mem_sign_mask(f_mask),
        .mem_memread(f_memread), .mem_memwrite(f_memwrite),
        .mem_read_data(f_read_data), .mem_stall(f_stall), .busy(f_busy)
    );

    // Memory model: stall rises the edge after a strobe and stays high two cycles.
    assign mem_read_data = model_data(mem_addr);
    assign mem_stall     = force_stall | (model_stall & ~mem_dead);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_stall <= 1'b0;
            model_left  <= 1'b0;
        end else if (mem_memread || mem_memwrite) begin
            model_stall <= 1'b1;
            model_left  <= 1'b1;
        end else if (model_left) begin
            model_left <= 1'b0;
        end else begin
            model_stall <= 1'b0;
        end
    end

    assign f_read_data = model_data(f_addr);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_stall <= 1'b0;
            f_left  <= 1'b0;
        end else if (f_memread || f_memwrite) begin
            f_stall <= 1'b1;
            f_left  <= 1'b1;
        end else if (f_left) begin
            f_left <= 1'b0;
        end else begin
            f_stall <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_memread)  rd_cnt <= rd_cnt + 1;
            if (mem_memwrite) wr_cnt <= wr_cnt + 1;
            if (mem_memread && mem_memwrite) both_cnt <= both_cnt + 1;
            if (mem_memread || mem_memwrite) begin
                last_cmd_addr  <= mem_addr;
                last_cmd_wdata <= mem_wdata;
                last_cmd_mask  <= mem_sign_mask;
            end
        end
    end

    task automatic start_req(input int port, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] mask, input logic timeout);
        exp_t e;
        if (!we && !timeout) exp_rd[port] = model_data(addr);
        e.port  = port;
        e.rdata = exp_rd[port];
        e.err   = timeout;
        sb.push_back(e);
        if (port == 0) begin
            p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_mask = mask; p0_req = 1'b1;
        end else begin
            p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_mask = mask; p1_req = 1'b1;
        end
    endtask

    task automatic wait_done(output int port, output int cyc);
        port = -1;
        cyc  = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (p0_done || p1_done) begin
                cyc  = i;
                port = (p0_done && p1_done) ? 2 : (p1_done ? 1 : 0);
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({p0_done, p1_done, p0_err, p1_err, busy, mem_memread, mem_memwrite} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0", {p0_done, p1_done, p0_err, p1_err, busy, mem_memread, mem_memwrite});
        end
        checks++;
        if ({p0_rdata, p1_rdata, mem_addr} !== 96'b0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {p0_rdata, p1_rdata, mem_addr});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || p0_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_release busy=%b done=%b exp=0", busy, p0_done);
        end
    endtask

    task automatic test_round_robin();
        int   port, cyc;
        exp_t e;
        logic [31:0] got;
        @(negedge clk);
        for (int k = 0; k < 4; k++) start_req(k % 2, 1'b0, (k % 2) ? 32'h204 : 32'h100, 32'h0, SM_WORD, 1'b0);
        for (int k = 0; k < 4; k++) begin
            wait_done(port, cyc);
            e   = sb.pop_front();
            got = (e.port == 1) ? p1_rdata : p0_rdata;
            checks++;
            if (port !== e.port) begin
                failures++;
                $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, port, e.port);
            end
            checks++;
            if (got !== e.rdata || (p0_err | p1_err) !== e.err) begin
                failures++;
                $display("FAIL rr_data[%0d] got=%h exp=%h", k, got, e.rdata);
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rr_idle busy=%b exp=0", busy);
        end
    endtask

    task automatic test_load();
        int   port, cyc, rd0;
        exp_t e;
        @(negedge clk);
        rd0 = rd_cnt;
        start_req(0, 1'b0, 32'h10, 32'h0, SM_BYTE, 1'b0);
        wait_done(port, cyc);
        e = sb.pop_front();
        p0_req = 1'b0;
        checks++;
        if (port !== 0 || cyc !== 5) begin
            failures++;
            $display("FAIL load_latency port=%0d cyc=%0d exp port=0 cyc=5", port, cyc);
        end
        checks++;
        if (p0_rdata !== e.rdata || p0_err !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL load_data got=%h err=%b busy=%b exp=%h err=0 busy=1", p0_rdata, p0_err, busy, e.rdata);
        end
        @(negedge clk);
        checks++;
        if (rd_cnt - rd0 !== 1 || last_cmd_addr !== 32'h10 || last_cmd_mask !== SM_BYTE) begin
            failures++;
            $display("FAIL load_cmd reads=%0d addr=%h mask=%b exp 1 00000010 0100", rd_cnt - rd0, last_cmd_addr, last_cmd_mask);
        end
    endtask

    task automatic test_store();
        int   port, cyc, rd0, wr0;
        exp_t e;
        @(negedge clk);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        start_req(1, 1'b1, 32'h23, 32'h0000_00AB, SM_WORD, 1'b0);
        wait_done(port, cyc);
        e = sb.pop_front();
        p1_req = 1'b0;
        checks++;
        if (port !== 1 || cyc !== 5 || p1_err !== 1'b0) begin
            failures++;
            $display("FAIL store_done port=%0d cyc=%0d err=%b exp 1 5 0", port, cyc, p1_err);
        end
        checks++;
        if (p1_rdata !== e.rdata || p0_rdata !== exp_rd[0]) begin
            failures++;
            $display("FAIL store_rdata p1=%h p0=%h exp %h %h", p1_rdata, p0_rdata, e.rdata, exp_rd[0]);
        end
        checks++;
        if (wr_cnt - wr0 !== 1 || rd_cnt !== rd0 || last_cmd_addr !== 32'h23 || last_cmd_wdata !== 32'hAB) begin
            failures++;
            $display("FAIL store_cmd writes=%0d reads=%0d addr=%h data=%h exp 1 0 23 ab",
                     wr_cnt - wr0, rd_cnt - rd0, last_cmd_addr, last_cmd_wdata);
        end
    endtask

    task automatic test_drop_after_grant();
        int   port, cyc;
        exp_t e;
        @(negedge clk);
        start_req(1, 1'b0, 32'h30, 32'h0, SM_HALF, 1'b0);
        @(negedge clk);
        p1_req = 1'b0;
        wait_done(port, cyc);
        e = sb.pop_front();
        checks++;
        if (port !== 1 || cyc !== 4 || p1_rdata !== e.rdata) begin
            failures++;
            $display("FAIL drop_req port=%0d cyc=%0d data=%h exp 1 4 %h", port, cyc, p1_rdata, e.rdata);
        end
    endtask

    task automatic test_timeout();
        int   port, cyc;
        exp_t e;
        mem_dead = 1'b1;
        @(negedge clk);
        start_req(0, 1'b0, 32'h44, 32'h0, SM_WORD, 1'b1);
        wait_done(port, cyc);
        e = sb.pop_front();
        p0_req = 1'b0;
        checks++;
        if (port !== 0 || cyc !== T + 3 || p0_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout port=%0d cyc=%0d err=%b exp 0 %0d 1", port, cyc, p0_err, T + 3);
        end
        checks++;
        if (p0_rdata !== e.rdata) begin
            failures++;
            $display("FAIL timeout_rdata got=%h exp=%h", p0_rdata, e.rdata);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || p0_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_idle busy=%b err=%b exp 0 0", busy, p0_err);
        end
        mem_dead = 1'b0;
    endtask

    task automatic test_reset_mid();
        int   port, cyc, seen;
        exp_t e;
        @(negedge clk);
        start_req(0, 1'b0, 32'h10, 32'h0, SM_BYTE, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || mem_stall !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_wait busy=%b stall=%b exp 1 1", busy, mem_stall);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_sign_mask, mem_memread, mem_memwrite,
             p0_done, p1_done, p0_err, p1_err, busy} !== 139'b0) begin
            failures++;
            $display("FAIL rst_mid_async busy=%b addr=%h rdata=%h exp all 0", busy, mem_addr, p0_rdata);
        end
        p0_req = 1'b0;
        sb.delete();
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (p0_done || p1_done) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL rst_mid_nodone got=%0d exp=0", seen);
        end
        start_req(0, 1'b0, 32'h10, 32'h0, SM_BYTE, 1'b0);
        wait_done(port, cyc);
        e = sb.pop_front();
        p0_req = 1'b0;
        checks++;
        if (port !== 0 || cyc !== 5 || p0_rdata !== e.rdata) begin
            failures++;
            $display("FAIL rst_mid_fresh port=%0d cyc=%0d data=%h exp 0 5 %h", port, cyc, p0_rdata, e.rdata);
        end
    endtask

    task automatic test_stall_idle();
        int   port, cyc, rd0, early;
        exp_t e;
        @(negedge clk);
        force_stall = 1'b1;
        rd0 = rd_cnt;
        early = 0;
        start_req(0, 1'b0, 32'h58, 32'h0, SM_HALF_U, 1'b0);
        repeat (3) begin
            @(negedge clk);
            if (mem_memread || mem_memwrite || busy) early++;
        end
        checks++;
        if (early !== 0) begin
            failures++;
            $display("FAIL stall_idle_hold got=%0d exp=0", early);
        end
        force_stall = 1'b0;
        wait_done(port, cyc);
        e = sb.pop_front();
        p0_req = 1'b0;
        checks++;
        if (port !== 0 || cyc !== 5 || p0_rdata !== e.rdata) begin
            failures++;
            $display("FAIL stall_idle_go port=%0d cyc=%0d data=%h exp 0 5 %h", port, cyc, p0_rdata, e.rdata);
        end
        checks++;
        if (rd_cnt - rd0 !== 1) begin
            failures++;
            $display("FAIL stall_idle_strobes got=%0d exp=1", rd_cnt - rd0);
        end
    endtask

    task automatic test_fixed_prio();
        int served0, served1, cyc;
        logic got1;
        served0 = 0;
        served1 = 0;
        cyc = 0;
        @(negedge clk);
        f0_req = 1'b1;
        f1_req = 1'b1;
        while (served0 < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (f1_done) served1++;
            if (f0_done) served0++;
        end
        f0_req = 1'b0;
        checks++;
        if (served0 !== 3 || served1 !== 0 || f0_rdata !== model_data(32'h40)) begin
            failures++;
            $display("FAIL fixed_prio p0=%0d p1=%0d rdata=%h exp 3 0 %h", served0, served1, f0_rdata, model_data(32'h40));
        end
        got1 = 1'b0;
        for (int i = 0; i < 20 && !got1; i++) begin
            @(negedge clk);
            if (f1_done) got1 = 1'b1;
        end
        f1_req = 1'b0;
        checks++;
        if (got1 !== 1'b1 || f1_rdata !== model_data(32'h80)) begin
            failures++;
            $display("FAIL fixed_prio_p1 done=%b rdata=%h exp 1 %h", got1, f1_rdata, model_data(32'h80));
        end
    endtask

    initial begin
        {p0_req, p0_we, p0_addr, p0_wdata, p0_mask} = '0;
        {p1_req, p1_we, p1_addr, p1_wdata, p1_mask} = '0;
        {f0_req, f1_req, force_stall, mem_dead} = '0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        test_reset();
        test_round_robin();
        test_load();
        test_store();
        test_drop_after_grant();
        test_timeout();
        test_reset_mid();
        test_stall_idle();
        test_fixed_prio();
        repeat (2) @(negedge clk);
        checks++;
        if (both_cnt !== 0 || sb.size() !== 0) begin
            failures++;
            $display("FAIL final both_strobes=%0d pending=%0d exp 0 0", both_cnt, sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
